fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 150 +++++++++++++++
 tb/tb_fetch_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: issues word requests, pairs in-order responses with PC+4, queues them for decode.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic        INST_VALID,
    output logic [31:0] INST_OUT,
    output logic [31:0] PCPLUS4_OUT,
    input  logic        INST_READY,
    output logic [3:0]  QUEUE_COUNT
);
    localparam int unsigned PW      = $clog2(DEPTH);
    localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

    typedef logic [PW-1:0] ptr_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [3:0]  count_q, count_d;
    logic [3:0]  out_q, out_d;
    logic [3:0]  stale_q, stale_d;
    ptr_t        q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    ptr_t        tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [31:0] q_inst_q [DEPTH];
    logic [31:0] q_inst_d [DEPTH];
    logic [31:0] q_pc4_q  [DEPTH];
    logic [31:0] q_pc4_d  [DEPTH];
    logic [31:0] tag_q    [DEPTH];
    logic [31:0] tag_d    [DEPTH];
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;

    logic        grant, live_rsp, bypass, pop, push;
    logic [31:0] rsp_pc4;

    always_comb begin
        IMEM_REQ    = !RESET && !REDIRECT && ((count_q + out_q) < DEPTH_C);
        IMEM_ADDR   = fetch_pc_q;
        QUEUE_COUNT = count_q;
        grant       = IMEM_REQ && IMEM_GNT;
        rsp_pc4     = tag_q[tag_rd_q];
        // The oldest stale_q responses in flight belong to the pre-redirect stream.
        live_rsp    = IMEM_RVALID && (stale_q == '0) && !REDIRECT;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass      = live_rsp && (count_q == '0);
`else
        bypass      = 1'b0;
`endif
        INST_VALID  = (count_q != '0) || bypass;
        if (count_q != '0) begin
            INST_OUT    = q_inst_q[q_rd_q];
            PCPLUS4_OUT = q_pc4_q[q_rd_q];
        end else if (bypass) begin
            INST_OUT    = IMEM_RDATA;
            PCPLUS4_OUT = rsp_pc4;
        end else begin
            INST_OUT    = hold_inst_q;
            PCPLUS4_OUT = hold_pc4_q;
        end
        pop  = (count_q != '0) && INST_READY && !REDIRECT;
        push = live_rsp && !(bypass && INST_READY);
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        count_d     = count_q;
        stale_d     = stale_q;
        q_rd_d      = q_rd_q;
        q_wr_d      = q_wr_q;
        tag_rd_d    = tag_rd_q;
        tag_wr_d    = tag_wr_q;
        q_inst_d    = q_inst_q;
        q_pc4_d     = q_pc4_q;
        tag_d       = tag_q;
        hold_inst_d = INST_OUT;
        hold_pc4_d  = PCPLUS4_OUT;
        out_d       = out_q + 4'(grant) - 4'(IMEM_RVALID);

        if (grant) begin
            tag_d[tag_wr_q] = fetch_pc_q + 32'd4;
            tag_wr_d        = tag_wr_q + ptr_t'(1);
            fetch_pc_d      = fetch_pc_q + 32'd4;
        end
        if (IMEM_RVALID) begin
            tag_rd_d = tag_rd_q + ptr_t'(1);
        end

        if (REDIRECT) begin
            // Everything still in flight after this cycle is from the old stream.
            fetch_pc_d = REDIRECT_PC & 32'hFFFF_FFFC;
            stale_d    = out_d;
            count_d    = '0;
            q_rd_d     = '0;
            q_wr_d     = '0;
        end else begin
            stale_d = stale_q - 4'(IMEM_RVALID && (stale_q != '0));
            if (push) begin
                q_inst_d[q_wr_q] = IMEM_RDATA;
                q_pc4_d[q_wr_q]  = rsp_pc4;
                q_wr_d           = q_wr_q + ptr_t'(1);
            end
            if (pop) begin
                q_rd_d = q_rd_q + ptr_t'(1);
            end
            count_d = count_q + 4'(push) - 4'(pop);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            fetch_pc_q  <= RESET_PC;
            count_q     <= '0;
            out_q       <= '0;
            stale_q     <= '0;
            q_rd_q      <= '0;
            q_wr_q      <= '0;
            tag_rd_q    <= '0;
            tag_wr_q    <= '0;
            hold_inst_q <= '0;
            hold_pc4_q  <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            count_q     <= count_d;
            out_q       <= out_d;
            stale_q     <= stale_d;
            q_rd_q      <= q_rd_d;
            q_wr_q      <= q_wr_d;
            tag_rd_q    <= tag_rd_d;
            tag_wr_q    <= tag_wr_d;
            hold_inst_q <= hold_inst_d;
            hold_pc4_q  <= hold_pc4_d;
        end
    end

    always_ff @(posedge CLOCK) begin
        q_inst_q <= q_inst_d;
        q_pc4_q  <= q_pc4_d;
        tag_q    <= tag_d;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: fixed vector table, directed redirect/wrap/bypass sequences, random traffic vs a queue model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLOCK = 1'b0;
    logic        RESET, REDIRECT, IMEM_GNT, IMEM_RVALID, INST_READY;
    logic [31:0] REDIRECT_PC, IMEM_RDATA;
    logic        IMEM_REQ, INST_VALID;
    logic [31:0] IMEM_ADDR, INST_OUT, PCPLUS4_OUT;
    logic [3:0]  QUEUE_COUNT;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .INST_VALID(INST_VALID), .INST_OUT(INST_OUT), .PCPLUS4_OUT(PCPLUS4_OUT),
        .INST_READY(INST_READY), .QUEUE_COUNT(QUEUE_COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] ^ a[15:0] ^ 16'h5A5A};
    endfunction

    // Reference model: outstanding requests in issue order, and the decode queue contents.
    typedef struct { logic [31:0] pc4; bit stale; int unsigned issued; } req_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc4; } ent_t;
    req_t        outst[$];
    ent_t        mq[$];
    logic [31:0] m_pc, m_last_inst, m_last_pc4;
    int unsigned cyc = 0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_inst, s_pc4;
    logic [3:0]  s_cnt;

    task automatic do_reset();
        RESET = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = '0; IMEM_GNT = 1'b0;
        IMEM_RVALID = 1'b0; IMEM_RDATA = '0; INST_READY = 1'b0;
        @(posedge CLOCK);
        @(negedge CLOCK);
        check("rst_req",   32'(IMEM_REQ), 32'd0);
        check("rst_valid", 32'(INST_VALID), 32'd0);
        check("rst_count", 32'(QUEUE_COUNT), 32'd0);
        check("rst_inst",  INST_OUT, 32'd0);
        check("rst_pc4",   PCPLUS4_OUT, 32'd0);
        check("rst_addr",  IMEM_ADDR, 32'h0000_0000);
        @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        outst.delete();
        mq.delete();
        m_pc = 32'h0000_0000;
        m_last_inst = '0;
        m_last_pc4 = '0;
    endtask

    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit gnt, input bit rv, input bit rdy);
        logic [31:0] rdata, rsp_pc4, e_inst, e_pc4;
        bit live, byp, e_req, e_valid;
        rv      = rv && (outst.size() != 0);
        rsp_pc4 = rv ? outst[0].pc4 : 32'd0;
        rdata   = rv ? word(rsp_pc4 - 32'd4) : $urandom;
        REDIRECT = redir; REDIRECT_PC = rpc; IMEM_GNT = gnt;
        IMEM_RVALID = rv; IMEM_RDATA = rdata; INST_READY = rdy;
        @(negedge CLOCK);
        e_req   = !redir && (mq.size() + outst.size() < DEPTH);
        live    = rv && !redir && !outst[0].stale;
        byp     = BYP && live && (mq.size() == 0);
        e_valid = (mq.size() != 0) || byp;
        if (mq.size() != 0) begin e_inst = mq[0].inst; e_pc4 = mq[0].pc4; end
        else if (byp)       begin e_inst = rdata;      e_pc4 = rsp_pc4;   end
        else                begin e_inst = m_last_inst; e_pc4 = m_last_pc4; end
        s_req = IMEM_REQ; s_addr = IMEM_ADDR; s_valid = INST_VALID;
        s_inst = INST_OUT; s_pc4 = PCPLUS4_OUT; s_cnt = QUEUE_COUNT;
        check("req",   32'(IMEM_REQ), 32'(e_req));
        check("addr",  IMEM_ADDR, m_pc);
        check("valid", 32'(INST_VALID), 32'(e_valid));
        check("inst",  INST_OUT, e_inst);
        check("pc4",   PCPLUS4_OUT, e_pc4);
        check("count", 32'(QUEUE_COUNT), 32'(mq.size()));
        if (e_valid) begin m_last_inst = e_inst; m_last_pc4 = e_pc4; end
        if (rv) void'(outst.pop_front());
        if (redir) begin
            mq.delete();
            foreach (outst[i]) outst[i].stale = 1'b1;
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (rdy && mq.size() != 0) void'(mq.pop_front());
            if (live && !(byp && rdy)) mq.push_back('{rdata, rsp_pc4});
            if (e_req && gnt) begin
                outst.push_back('{m_pc + 32'd4, 1'b0, cyc});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge CLOCK);
        #1;
        cyc++;
    endtask

    typedef struct {
        bit gnt; bit rv; logic [31:0] rdata; bit rdy;
        bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_inst; logic [31:0] e_pc4; logic [3:0] e_cnt;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input bit gnt, input bit rv, input logic [31:0] rdata, input bit rdy,
                                input bit e_req, input logic [31:0] e_addr, input bit e_valid,
                                input logic [31:0] e_inst, input logic [31:0] e_pc4, input logic [3:0] e_cnt);
        vecs.push_back('{gnt, rv, rdata, rdy, e_req, e_addr, e_valid, e_inst, e_pc4, e_cnt});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Grant every cycle, 1-cycle response latency, decode stalled for 10 cycles then released.
        add(1, 0, 32'd0,     0, 1, 32'd0,  0,   32'd0,                 32'd0,                  4'd0);
        add(1, 1, word(0),   0, 1, 32'd4,  BYP, BYP ? word(0) : 32'd0, BYP ? 32'd4 : 32'd0,    4'd0);
        add(1, 1, word(4),   0, 1, 32'd8,  1,   word(0),               32'd4,                  4'd1);
        add(1, 1, word(8),   0, 1, 32'd12, 1,   word(0),               32'd4,                  4'd2);
        add(1, 1, word(12),  0, 0, 32'd16, 1,   word(0),               32'd4,                  4'd3);
        for (int r = 5; r < 10; r++)
            add(1, 0, 32'd0, 0, 0, 32'd16, 1,   word(0),               32'd4,                  4'd4);
        add(1, 0, 32'd0,     1, 0, 32'd16, 1,   word(0),               32'd4,                  4'd4);
        add(1, 0, 32'd0,     1, 1, 32'd16, 1,   word(4),               32'd8,                  4'd3);
        add(1, 1, word(16),  1, 1, 32'd20, 1,   word(8),               32'd12,                 4'd2);
        add(1, 1, word(20),  1, 1, 32'd24, 1,   word(12),              32'd16,                 4'd2);
        add(1, 1, word(24),  1, 1, 32'd28, 1,   word(16),              32'd20,                 4'd2);

        do_reset();
        foreach (vecs[i]) begin
            REDIRECT = 1'b0; REDIRECT_PC = '0; IMEM_GNT = vecs[i].gnt;
            IMEM_RVALID = vecs[i].rv; IMEM_RDATA = vecs[i].rdata; INST_READY = vecs[i].rdy;
            @(negedge CLOCK);
            check($sformatf("vec%0d_req", i),   32'(IMEM_REQ),    32'(vecs[i].e_req));
            check($sformatf("vec%0d_addr", i),  IMEM_ADDR,        vecs[i].e_addr);
            check($sformatf("vec%0d_valid", i), 32'(INST_VALID),  32'(vecs[i].e_valid));
            check($sformatf("vec%0d_inst", i),  INST_OUT,         vecs[i].e_inst);
            check($sformatf("vec%0d_pc4", i),   PCPLUS4_OUT,      vecs[i].e_pc4);
            check($sformatf("vec%0d_count", i), 32'(QUEUE_COUNT), 32'(vecs[i].e_cnt));
            @(posedge CLOCK);
            #1;
        end

        // Redirect with three requests in flight; misaligned target is forced to a word boundary.
        do_reset();
        repeat (3) cycle(0, 0, 1, 0, 1);
        cycle(1, 32'h43, 1, 0, 1);
        check("redir_req_low", 32'(s_req), 32'd0);
        cycle(0, 0, 1, 1, 1);
        check("redir_addr", s_addr, 32'h40);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);
        check("stale_dropped_valid", 32'(s_valid), 32'd0);
        check("stale_dropped_count", 32'(s_cnt), 32'd0);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1);
        check("redir_inst", s_inst, word(32'h40));
        check("redir_pc4",  s_pc4, 32'h44);

        // Redirect in the same cycle as a live response and a pop.
        do_reset();
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(1, 32'h80, 0, 1, 1);
        cycle(0, 0, 0, 0, 1);
        check("redir_pop_count", 32'(s_cnt), 32'd0);
        check("redir_pop_valid", 32'(s_valid), 32'd0);
        check("redir_pop_hold",  s_inst, word(32'd0));
        check("redir_pop_addr",  s_addr, 32'h80);

        // Fetch PC wrap at the top of the address space.
        do_reset();
        cycle(1, 32'hFFFF_FFFC, 0, 0, 1);
        cycle(0, 0, 1, 0, 1);
        check("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 1, 1);
        check("wrap_addr_zero", s_addr, 32'h0);
        cycle(0, 0, 0, 0, 1);
        check("wrap_pc4", s_pc4, 32'h0);
        check("wrap_inst", s_inst, word(32'hFFFF_FFFC));

        // Response into an empty queue with decode ready.
        do_reset();
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 0, 1, 1);
        check("empty_rsp_valid_now", 32'(s_valid), 32'(BYP));
        cycle(0, 0, 0, 0, 1);
        check("empty_rsp_valid_next", 32'(s_valid), 32'(!BYP));

        do_reset();
        for (int i = 0; i < 2400; i++) begin
            bit rd, g, rv, rdy;
            logic [31:0] rpc;
            if (i % 600 == 599) begin
                do_reset();
            end else begin
                rd  = ($urandom_range(0, 99) < 5);
                rpc = $urandom;
                g   = ($urandom_range(0, 99) < 70);
                rv  = (outst.size() != 0) && (outst[0].issued < cyc) && ($urandom_range(0, 99) < 60);
                rdy = ($urandom_range(0, 99) < 70);
                cycle(rd, rpc, g, rv, rdy);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
